// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM state encoding and decode helpers for the sequential ALU.
package alu_pkg;

   localparam int unsigned OP_W = 4;

   localparam logic [OP_W-1:0] ALU_ADD  = 4'h0;
   localparam logic [OP_W-1:0] ALU_SUB  = 4'h1;
   localparam logic [OP_W-1:0] ALU_AND  = 4'h2;
   localparam logic [OP_W-1:0] ALU_OR   = 4'h3;
   localparam logic [OP_W-1:0] ALU_XOR  = 4'h4;
   localparam logic [OP_W-1:0] ALU_NAND = 4'h5;
   localparam logic [OP_W-1:0] ALU_SHL  = 4'h6;
   localparam logic [OP_W-1:0] ALU_SHR  = 4'h7;
   localparam logic [OP_W-1:0] ALU_MUL  = 4'h8;
   localparam logic [OP_W-1:0] ALU_MULH = 4'h9;
   localparam logic [OP_W-1:0] ALU_DIV  = 4'hA;
   localparam logic [OP_W-1:0] ALU_REM  = 4'hB;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   // Opcodes 8-11 belong to the iterative multiply/divide unit.
   function automatic logic is_muldiv(input logic [OP_W-1:0] op);
      return (op[3:2] == 2'b10);
   endfunction

   function automatic logic is_div_op(input logic [OP_W-1:0] op);
      return (op == ALU_DIV) || (op == ALU_REM);
   endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle between the CPU datapath and the sequential ALU.
interface alu_seq_if #(
   parameter int unsigned WIDTH = 32
);
   logic             start;
   logic             ready;
   logic [3:0]       op;
   logic [WIDTH-1:0] data0;
   logic [WIDTH-1:0] data1;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             div_by_zero;
   logic             illegal;

   modport master (
      output start, op, data0, data1,
      input  ready, done, result, div_by_zero, illegal
   );

   modport slave (
      input  start, op, data0, data1,
      output ready, done, result, div_by_zero, illegal
   );
endinterface

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per step.
// o_lo/o_hi present the register contents as they will be after the current step.
module alu_muldiv_iter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic             i_step,
   input  logic             i_is_div,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH-1:0] o_lo,
   output logic [WIDTH-1:0] o_hi,
   output logic             o_last
);

   localparam int unsigned CW = $clog2(WIDTH);

   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic [WIDTH-1:0] r_b;
   logic [CW-1:0]    r_cnt;
   logic             r_is_div;

   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_shift;
   logic [WIDTH:0]   w_diff;
   logic [WIDTH-1:0] w_hi_nxt;
   logic [WIDTH-1:0] w_lo_nxt;

   // Divide: partial remainder never exceeds twice the divisor, so the borrow bit is the compare.
   always_comb begin
      w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : (WIDTH+1)'(0));
      w_shift  = {r_hi, r_lo[WIDTH-1]};
      w_diff   = w_shift - {1'b0, r_b};
      w_hi_nxt = r_hi;
      w_lo_nxt = r_lo;
      if (r_is_div) begin
         if (!w_diff[WIDTH]) begin
            w_hi_nxt = w_diff[WIDTH-1:0];
            w_lo_nxt = {r_lo[WIDTH-2:0], 1'b1};
         end else begin
            w_hi_nxt = w_shift[WIDTH-1:0];
            w_lo_nxt = {r_lo[WIDTH-2:0], 1'b0};
         end
      end else begin
         w_hi_nxt = w_sum[WIDTH:1];
         w_lo_nxt = {w_sum[0], r_lo[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hi     <= '0;
         r_lo     <= '0;
         r_b      <= '0;
         r_cnt    <= '0;
         r_is_div <= 1'b0;
      end else if (i_load) begin
         r_hi     <= '0;
         r_lo     <= i_a;
         r_b      <= i_b;
         r_cnt    <= '0;
         r_is_div <= i_is_div;
      end else if (i_step) begin
         r_hi     <= w_hi_nxt;
         r_lo     <= w_lo_nxt;
         r_cnt    <= r_cnt + CW'(1);
      end
   end

   assign o_lo   = w_lo_nxt;
   assign o_hi   = w_hi_nxt;
   assign o_last = (r_cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle basic ops plus an optional iterative multiply/divide path.
module alu_seq
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH     = 32,
   parameter bit          MULDIV_EN = 1'b1
) (
   input  logic      clk,
   input  logic      rst,
   alu_seq_if.slave  bus
);

   localparam int unsigned SHW = $clog2(WIDTH);

   state_t           r_state;
   logic             r_ready;
   logic             r_done;
   logic [WIDTH-1:0] r_result;
   logic             r_dz;
   logic             r_ill;
   logic [OP_W-1:0]  r_op;
   logic             r_dz_pend;

   logic             w_accept;
   logic             w_is_md;
   logic             w_illegal;
   logic             w_go_calc;
   logic             w_sh_big;
   logic [SHW-1:0]   w_sh_amt;
   logic [WIDTH-1:0] w_basic;
   logic [WIDTH-1:0] w_lo;
   logic [WIDTH-1:0] w_hi;
   logic             w_last;
   logic [WIDTH-1:0] w_md_res;

   assign w_accept  = bus.start && r_ready;
   assign w_is_md   = is_muldiv(bus.op);
   assign w_illegal = (bus.op[3:2] == 2'b11) || (w_is_md && !MULDIV_EN);
   assign w_go_calc = w_accept && w_is_md && MULDIV_EN;
   assign w_sh_big  = |bus.data1[WIDTH-1:SHW];
   assign w_sh_amt  = bus.data1[SHW-1:0];

   // Basic-op datapath; anything outside 0-7 produces zero.
   always_comb begin
      w_basic = '0;
      case (bus.op)
         ALU_ADD:  w_basic = bus.data0 + bus.data1;
         ALU_SUB:  w_basic = bus.data0 - bus.data1;
         ALU_AND:  w_basic = bus.data0 & bus.data1;
         ALU_OR:   w_basic = bus.data0 | bus.data1;
         ALU_XOR:  w_basic = bus.data0 ^ bus.data1;
         ALU_NAND: w_basic = ~(bus.data0 & bus.data1);
         ALU_SHL:  w_basic = w_sh_big ? '0 : (bus.data0 << w_sh_amt);
         ALU_SHR:  w_basic = w_sh_big ? '0 : (bus.data0 >> w_sh_amt);
         default:  w_basic = '0;
      endcase
   end

   generate
      if (MULDIV_EN) begin : g_muldiv
         alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
            .clk      (clk),
            .rst      (rst),
            .i_load   (w_go_calc),
            .i_step   (r_state == CALC),
            .i_is_div (is_div_op(bus.op)),
            .i_a      (bus.data0),
            .i_b      (bus.data1),
            .o_lo     (w_lo),
            .o_hi     (w_hi),
            .o_last   (w_last)
         );
      end else begin : g_no_muldiv
         assign w_lo   = '0;
         assign w_hi   = '0;
         assign w_last = 1'b0;
      end
   endgenerate

   assign w_md_res = ((r_op == ALU_MULH) || (r_op == ALU_REM)) ? w_hi : w_lo;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_ready   <= 1'b1;
         r_done    <= 1'b0;
         r_result  <= '0;
         r_dz      <= 1'b0;
         r_ill     <= 1'b0;
         r_op      <= '0;
         r_dz_pend <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE, DONE: begin
               if (w_accept) begin
                  if (w_go_calc) begin
                     r_state   <= CALC;
                     r_ready   <= 1'b0;
                     r_op      <= bus.op;
                     r_dz_pend <= is_div_op(bus.op) && (bus.data1 == '0);
                  end else begin
                     r_state  <= DONE;
                     r_done   <= 1'b1;
                     r_result <= w_basic;
                     r_ill    <= w_illegal;
                     r_dz     <= 1'b0;
                  end
               end else begin
                  r_state <= IDLE;
               end
            end
            // Division by zero falls out of the restoring algorithm as all-ones / dividend.
            CALC: begin
               if (w_last) begin
                  r_state  <= DONE;
                  r_ready  <= 1'b1;
                  r_done   <= 1'b1;
                  r_result <= w_md_res;
                  r_dz     <= r_dz_pend;
                  r_ill    <= 1'b0;
               end
            end
            default: begin
               r_state <= IDLE;
               r_ready <= 1'b1;
            end
         endcase
      end
   end

   assign bus.ready       = r_ready;
   assign bus.done        = r_done;
   assign bus.result      = r_result;
   assign bus.div_by_zero = r_dz;
   assign bus.illegal     = r_ill;

endmodule
